pp_row_sequencer: RTL and testbench

Parametrised, sequential partial-product generator for the Dadda multiplier front end. It accepts one operand pair per transaction and streams that pair's partial-product rows to the compression tree, one row per cycle, over a valid/ready handshake. Two row-generation modes are supported:

- Mode 0: unsigned AND-array, one row per multiplier bit.
- Mode 1: signed radix-4 Booth, half the rows.

Each row carries its left-shift weight and a two's-complement correction bit, so the downstream tree can sum rows without further decoding.

---
 rtl/pp_row_sequencer.sv | 150 +++++++++++++++
 tb/tb_pp_row_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_row_sequencer.sv
// Sequential partial-product row generator for the Dadda multiplier front end.
// Streams one unsigned AND-array row or one radix-4 Booth row per cycle over valid/ready.
module pp_row_sequencer #(
    parameter int WIDTH = 32,
    localparam int RW = WIDTH + 2,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_row,
    output logic             out_neg,
    output logic [SW-1:0]    out_shift,
    output logic             out_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [RW-1:0] row;
        logic          neg;
        logic [SW-1:0] shift;
        logic          last;
    } row_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [SW-1:0]    idx_q, idx_d;
    row_t             row_q, row_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    // Row k of the transaction: k is the multiplier bit (mode 0) or the Booth digit index (mode 1).
    function automatic row_t gen_row(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic mode, input logic [SW-1:0] k);
        row_t          r;
        logic [RW-1:0] sa;
        logic [WIDTH:0] bx;
        logic [2:0]    trip;
        r    = '0;
        sa   = {{2{a[WIDTH-1]}}, a};
        bx   = {b, 1'b0};
        trip = '0;
        if (!mode) begin
            r.row   = b[k] ? {2'b00, a} : '0;
            r.shift = k;
            r.last  = (k == SW'(WIDTH - 1));
        end else begin
            // bx holds the implicit b[-1] = 0 below the LSB, so the triplet starts at bit 2k
            trip = 3'(bx >> {k, 1'b0});
            unique case (trip)
                3'b001, 3'b010: r.row = sa;
                3'b011:         r.row = sa << 1;
                3'b100: begin
                    r.row = ~(sa << 1);
                    r.neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    r.row = ~sa;
                    r.neg = 1'b1;
                end
                default:        r.row = '0;
            endcase
            r.shift = SW'({k, 1'b0});
            r.last  = (k == SW'(WIDTH / 2 - 1));
        end
        return r;
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: every signal gets a hold-value default first, so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        row_d   = row_q;
        valid_d = valid_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (in_valid && ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    mode_d  = in_mode;
                    idx_d   = '0;
                    row_d   = gen_row(in_a, in_b, in_mode, '0);
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                ready_d = 1'b0;
                if (valid_q && out_ready) begin
                    if (row_q.last) begin
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + SW'(1);
                        row_d = gen_row(a_q, b_q, mode_q, idx_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_row   = row_q.row;
    assign out_neg   = row_q.neg;
    assign out_shift = row_q.shift;
    assign out_last  = row_q.last;

endmodule

// File: tb/tb_pp_row_sequencer.sv
// Bench for pp_row_sequencer: WIDTH=8 row-level model with directed cases,
// plus a WIDTH=32 instance checked by reconstructing each product from its rows.
module tb_pp_row_sequencer;

    typedef struct {
        logic [9:0]  row;
        logic        neg;
        logic [2:0]  shift;
        logic        last;
        logic        mode;
        logic [15:0] prod;
    } exp_row_t;

    typedef struct {
        logic [9:0] row;
        logic       neg;
        logic [2:0] shift;
        logic       last;
    } act_row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_neg, out_last;
    logic [7:0] in_a, in_b;
    logic [9:0] out_row;
    logic [2:0] out_shift;

    logic        v32, rdy32, m32, ov32, or32, neg32, last32;
    logic [31:0] a32, b32;
    logic [33:0] row32;
    logic [4:0]  sh32;

    pp_row_sequencer #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_neg(out_neg),
        .out_shift(out_shift), .out_last(out_last)
    );

    pp_row_sequencer #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32), .in_mode(m32),
        .out_valid(ov32), .out_ready(or32), .out_row(row32), .out_neg(neg32),
        .out_shift(sh32), .out_last(last32)
    );

    int          checks = 0;
    int          passed = 0;
    exp_row_t    mq[$];
    act_row_t    log_q[$];
    int          acc_cyc[$];
    logic [15:0] acc = '0;
    logic [15:0] last_sum = '0;
    logic        seen_edge;
    int          cyc = 0;
    logic [63:0] exp32[$];
    logic        md32[$];
    logic [63:0] acc32 = '0;
    int          rows32 = 0;
    int          txn32 = 0;
    logic [7:0]  corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Row k straight from the arithmetic meaning of each mode: a bit-weighted copy of A,
    // or Booth digit d in {-2..2} times signed A, negatives as one's complement plus neg.
    function automatic exp_row_t model_row(input logic [7:0] a, input logic [7:0] b,
                                           input logic mode, input int k);
        exp_row_t r;
        int d, av, lo;
        r.row  = '0;
        r.neg  = 1'b0;
        r.mode = mode;
        if (!mode) begin
            r.row   = b[k] ? {2'b00, a} : 10'd0;
            r.shift = 3'(k);
            r.last  = (k == 7);
            r.prod  = 16'(int'(a) * int'(b));
        end else begin
            lo = (k == 0) ? 0 : int'(b[2*k-1]);
            d  = -2 * int'(b[2*k+1]) + int'(b[2*k]) + lo;
            av = int'($signed(a));
            if (d < 0) begin
                r.row = ~10'(-d * av);
                r.neg = 1'b1;
            end else begin
                r.row = 10'(d * av);
            end
            r.shift = 3'(2 * k);
            r.last  = (k == 3);
            r.prod  = 16'(int'($signed(a)) * int'($signed(b)));
        end
        return r;
    endfunction

    function automatic void push_txn(input logic [7:0] a, input logic [7:0] b, input logic mode);
        int n = mode ? 4 : 8;
        for (int k = 0; k < n; k++) mq.push_back(model_row(a, b, mode, k));
    endfunction

    function automatic logic [63:0] prod32(input logic [31:0] a, input logic [31:0] b, input logic m);
        longint sa, sb;
        if (m) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        return 64'(sa * sb);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_row_t    e;
        logic [15:0] ext;
        if (!rst_n) begin
            mq.delete();
            acc = '0;
        end else begin
            check("in_ready", 64'(in_ready), 64'((mq.size() == 0) && seen_edge));
            check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (out_valid && mq.size() != 0) begin
                e = mq[0];
                check("out_row", 64'(out_row), 64'(e.row));
                check("out_neg", 64'(out_neg), 64'(e.neg));
                check("out_shift", 64'(out_shift), 64'(e.shift));
                check("out_last", 64'(out_last), 64'(e.last));
                if (out_ready) begin
                    ext = e.mode ? {{6{out_row[9]}}, out_row} : {6'b0, out_row};
                    acc = acc + ((ext + 16'(out_neg)) << out_shift);
                    log_q.push_back('{out_row, out_neg, out_shift, out_last});
                    void'(mq.pop_front());
                    if (e.last) begin
                        check("sum", 64'(acc), 64'(e.prod));
                        last_sum = acc;
                        acc = '0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_txn(in_a, in_b, in_mode);
                acc_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] ext;
        if (!rst_n) begin
            exp32.delete();
            md32.delete();
            acc32  = '0;
            rows32 = 0;
        end else begin
            check("out_valid32", 64'(ov32), 64'(exp32.size() != 0));
            if (ov32 && or32 && exp32.size() != 0) begin
                ext    = md32[0] ? {{30{row32[33]}}, row32} : {30'b0, row32};
                acc32  = acc32 + ((ext + 64'(neg32)) << sh32);
                rows32 = rows32 + 1;
                if (last32) begin
                    check("sum32", acc32, exp32[0]);
                    check("rows32", 64'(rows32), 64'(md32[0] ? 16 : 32));
                    void'(exp32.pop_front());
                    void'(md32.pop_front());
                    acc32  = '0;
                    rows32 = 0;
                    txn32  = txn32 + 1;
                end
            end
            if (v32 && rdy32) begin
                exp32.push_back(prod32(a32, b32, m32));
                md32.push_back(m32);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
        int t = 0;
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                timeout("send");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_mode = ~m;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic m);
        int t = 0;
        a32 = a; b32 = b; m32 = m; v32 = 1'b1;
        while (!rdy32) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                timeout("send32");
                v32 = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        a32 = ~a; b32 = ~b; m32 = ~m;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(in_ready && !out_valid && mq.size() == 0)) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                timeout(name);
                return;
            end
        end
    endtask

    task automatic wait_log(input int n, input string name);
        int t = 0;
        while (log_q.size() < n) begin
            @(posedge clk); #1;
            t++;
            if (t > 100) begin
                timeout(name);
                return;
            end
        end
    endtask

    task automatic back2back(input logic m, input int gap, input string name);
        int t = 0;
        int n0 = acc_cyc.size();
        in_a = 8'h5A; in_b = 8'hC3; in_mode = m; in_valid = 1'b1;
        while (acc_cyc.size() < n0 + 2 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (acc_cyc.size() == n0 + 1) begin
                in_a = 8'hE7; in_b = 8'h3C;
            end
        end
        in_valid = 1'b0;
        if (acc_cyc.size() < n0 + 2) timeout(name);
        else check(name, 64'(acc_cyc[n0+1] - acc_cyc[n0]), 64'(gap));
        wait_idle(name);
    endtask

    initial begin
        exp_row_t p;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; m32 = 1'b0; or32 = 1'b1;

        p = model_row(8'hB5, 8'h05, 1'b0, 2);
        check("model_m0_row2", 64'(p.row), 64'h0B5);
        p = model_row(8'h07, 8'hFD, 1'b1, 1);
        check("model_m1_row1", 64'({p.neg, p.shift, p.row}), 64'({1'b1, 3'd2, 10'h3F8}));
        p = model_row(8'h80, 8'h80, 1'b1, 3);
        check("model_m1_row3", 64'({p.neg, p.shift, p.row}), 64'({1'b1, 3'd6, 10'h0FF}));
        p = model_row(8'h07, 8'hFD, 1'b1, 0);
        check("model_prod", 64'(p.prod), 64'hFFEB);

        #12;
        check("reset_outs", 64'({out_valid, out_row, out_neg, out_shift, out_last, in_ready}), 64'(0));
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        check("ready_after_edge", 64'(in_ready), 64'(1));

        log_q.delete();
        send(8'hB5, 8'h05, 1'b0);
        wait_idle("t1");
        check("t1_sum", 64'(last_sum), 64'h0389);
        check("t1_rows", 64'(log_q.size()), 64'(8));
        if (log_q.size() == 8) begin
            check("t1_row0", 64'(log_q[0].row), 64'h0B5);
            check("t1_row1", 64'(log_q[1].row), 64'h000);
            check("t1_row2", 64'(log_q[2].row), 64'h0B5);
            check("t1_last6", 64'(log_q[6].last), 64'(0));
            check("t1_last7", 64'({log_q[7].last, log_q[7].shift}), 64'({1'b1, 3'd7}));
        end

        log_q.delete();
        send(8'h07, 8'hFD, 1'b1);
        wait_idle("t2");
        check("t2_sum", 64'(last_sum), 64'hFFEB);
        check("t2_rows", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4) begin
            check("t2_row0", 64'({log_q[0].neg, log_q[0].shift, log_q[0].row}), 64'({1'b0, 3'd0, 10'h007}));
            check("t2_row1", 64'({log_q[1].neg, log_q[1].shift, log_q[1].row}), 64'({1'b1, 3'd2, 10'h3F8}));
            check("t2_row3", 64'({log_q[3].neg, log_q[3].row}), 64'(0));
        end

        log_q.delete();
        send(8'h80, 8'h80, 1'b1);
        wait_idle("t3");
        check("t3_sum", 64'(last_sum), 64'h4000);
        if (log_q.size() == 4)
            check("t3_row3", 64'({log_q[3].neg, log_q[3].shift, log_q[3].row}), 64'({1'b1, 3'd6, 10'h0FF}));
        else
            check("t3_rows", 64'(log_q.size()), 64'(4));

        log_q.delete();
        send(8'h11, 8'h0F, 1'b0);
        wait_log(1, "t4_row1");
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h05; in_b = 8'h06; in_mode = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_ready", 64'(in_ready), 64'(0));
            check("bp_row1", 64'({out_valid, out_shift, out_row, out_last}), 64'({1'b1, 3'd1, 10'h011, 1'b0}));
        end
        out_ready = 1'b1;
        send(8'h05, 8'h06, 1'b1);
        check("bp_p1_sum", 64'(last_sum), 64'h00FF);
        check("bp_p1_rows", 64'(log_q.size()), 64'(8));
        wait_idle("t4");
        check("bp_p2_sum", 64'(last_sum), 64'h001E);

        log_q.delete();
        send(8'hFF, 8'hFF, 1'b0);
        wait_log(2, "t5_row2");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'({out_valid, out_row, out_neg, out_shift, out_last, in_ready}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rst_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        check("rst_ready_high", 64'(in_ready), 64'(1));
        log_q.delete();
        send(8'h03, 8'h02, 1'b0);
        wait_idle("t5");
        check("t5_sum", 64'(last_sum), 64'h0006);
        if (log_q.size() == 8) begin
            check("t5_row0", 64'(log_q[0].row), 64'h000);
            check("t5_row1", 64'(log_q[1].row), 64'h003);
        end else begin
            check("t5_rows", 64'(log_q.size()), 64'(8));
        end

        back2back(1'b0, 9, "b2b_mode0");
        back2back(1'b1, 5, "b2b_mode1");

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    send(corners[i], corners[j], 1'(m));
        repeat (200) send(8'($urandom), 8'($urandom), 1'($urandom));
        wait_idle("sweep8");

        send32(32'h8000_0000, 32'h8000_0000, 1'b1);
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send32(32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
        for (int n = 0; n < 40; n++) send32(32'($urandom), 32'($urandom), 1'(n));
        begin
            int t = 0;
            while (txn32 < 43 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("txn32", 64'(txn32), 64'(43));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
